// File: rtl/reaction_timer.sv
// rtl/reaction_timer.sv - F1 start-light reaction timer: false start, timeout and result reporting
// Optional best-time tracking is enabled by defining REACTION_BEST_TIME_EN.
module reaction_timer #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arm,
  input  logic                 lights_out,
  input  logic                 tick,
  input  logic                 btn,
  output logic                 busy,
  output logic                 react_valid,
  output logic [CNT_WIDTH-1:0] react_time,
  output logic                 timeout_err,
  output logic                 false_start
`ifdef REACTION_BEST_TIME_EN
  ,
  output logic [CNT_WIDTH-1:0] best_time
`endif
);

  localparam logic [CNT_WIDTH-1:0] MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_TIMING,
    S_DONE,
    S_FALSE
  } state_t;

  state_t               state, next_state;
  logic [CNT_WIDTH-1:0] count;
  logic                 btn_q;
  logic                 btn_rise;
  logic                 count_clr, count_inc;
  logic                 load_result, load_timeout;
  logic                 fs_set, fs_clr;

  // A level held across arm never looks like a press; only fresh rising edges do.
  assign btn_rise = btn & ~btn_q;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state   = state;
    count_clr    = 1'b0;
    count_inc    = 1'b0;
    load_result  = 1'b0;
    load_timeout = 1'b0;
    fs_set       = 1'b0;
    fs_clr       = 1'b0;
    busy         = 1'b0;
    react_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        if (arm) next_state = S_ARMED;
      end
      S_ARMED: begin
        busy = 1'b1;
        if (btn_rise) begin
          next_state = S_FALSE;
          fs_set     = 1'b1;
        end else if (lights_out) begin
          next_state = S_TIMING;
          count_clr  = 1'b1;
        end
      end
      S_TIMING: begin
        busy = 1'b1;
        // A press wins over a coincident tick, so the tick is not counted.
        if (btn_rise) begin
          next_state  = S_DONE;
          load_result = 1'b1;
        end else if (count == MAX) begin
          next_state   = S_DONE;
          load_result  = 1'b1;
          load_timeout = 1'b1;
        end else if (tick) begin
          count_inc = 1'b1;
        end
      end
      S_DONE: begin
        react_valid = 1'b1;
        next_state  = S_IDLE;
      end
      S_FALSE: begin
        if (arm) begin
          next_state = S_ARMED;
          fs_clr     = 1'b1;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      btn_q       <= 1'b0;
      react_time  <= '0;
      timeout_err <= 1'b0;
      false_start <= 1'b0;
`ifdef REACTION_BEST_TIME_EN
      best_time   <= MAX;
`endif
    end else begin
      btn_q <= btn;
      if (count_clr)      count <= '0;
      else if (count_inc) count <= count + 1'b1;
      if (load_result) begin
        react_time  <= load_timeout ? MAX : count;
        timeout_err <= load_timeout;
`ifdef REACTION_BEST_TIME_EN
        if (!load_timeout && (count < best_time)) best_time <= count;
`endif
      end
      if (fs_set)      false_start <= 1'b1;
      else if (fs_clr) false_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reaction_timer.sv
// tb/tb_reaction_timer.sv - directed self-checking bench for reaction_timer (16-bit and 4-bit counters)
module tb_reaction_timer;

  logic        clk = 1'b0;
  logic        rst, arm, lights_out, tick, btn;
  logic        busy, react_valid, timeout_err, false_start;
  logic [15:0] react_time;
  logic        busy4, react_valid4, timeout_err4, false_start4;
  logic [3:0]  react_time4;
`ifdef REACTION_BEST_TIME_EN
  logic [15:0] best_time;
  logic [3:0]  best_time4;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int rv_cnt   = 0;
  int rv4_cnt  = 0;
  int rv_snap, rv4_snap;

  always #5 clk = ~clk;

  reaction_timer #(.CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .arm(arm), .lights_out(lights_out), .tick(tick), .btn(btn),
    .busy(busy), .react_valid(react_valid), .react_time(react_time),
    .timeout_err(timeout_err), .false_start(false_start)
`ifdef REACTION_BEST_TIME_EN
    , .best_time(best_time)
`endif
  );

  reaction_timer #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .arm(arm), .lights_out(lights_out), .tick(tick), .btn(btn),
    .busy(busy4), .react_valid(react_valid4), .react_time(react_time4),
    .timeout_err(timeout_err4), .false_start(false_start4)
`ifdef REACTION_BEST_TIME_EN
    , .best_time(best_time4)
`endif
  );

  always @(negedge clk) begin
    if (react_valid)  rv_cnt  <= rv_cnt + 1;
    if (react_valid4) rv4_cnt <= rv4_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_arm();
    arm = 1'b1; cyc(1); arm = 1'b0;
  endtask

  task automatic do_lights();
    lights_out = 1'b1; cyc(1); lights_out = 1'b0;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1; cyc(1); tick = 1'b0; cyc(1);
    end
  endtask

  // Leaves the DUT in the cycle after the press edge (DONE when timing).
  task automatic press();
    btn = 1'b1; cyc(1); btn = 1'b0;
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; lights_out = 1'b0; tick = 1'b0; btn = 1'b0;
    cyc(2);
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_valid", react_valid, 0);
    check("rst_time", react_time, 0);
    check("rst_tmo", timeout_err, 0);
    check("rst_fs", false_start, 0);
`ifdef REACTION_BEST_TIME_EN
    check("rst_best", best_time, 16'hFFFF);
`endif

    // Normal round: 7 ticks, press 2 cycles after the 7th tick
    do_arm();
    check("norm_busy_armed", busy, 1);
    cyc(4);
    do_lights();
    check("norm_busy_timing", busy, 1);
    do_ticks(7);
    cyc(1);
    rv_snap = rv_cnt;
    press();
    check("norm_valid", react_valid, 1);
    check("norm_time", react_time, 7);
    check("norm_tmo", timeout_err, 0);
    check("norm_busy_done", busy, 0);
    cyc(1);
    check("norm_valid_drop", react_valid, 0);
    check("norm_one_pulse", rv_cnt - rv_snap, 1);

    // False start, then late lights_out is ignored
    rv_snap = rv_cnt;
    do_arm();
    press();
    check("fs_flag", false_start, 1);
    cyc(2);
    do_lights();
    cyc(3);
    check("fs_hold", false_start, 1);
    check("fs_busy", busy, 0);
    check("fs_time_kept", react_time, 7);
    check("fs_no_valid", rv_cnt - rv_snap, 0);
    do_arm();
    check("fs_clear", false_start, 0);
    check("fs_rearm_busy", busy, 1);

    // btn_rise and lights_out together in ARMED -> false start
    cyc(1);
    btn = 1'b1; lights_out = 1'b1; cyc(1); btn = 1'b0; lights_out = 1'b0;
    check("sim_fs", false_start, 1);
    check("sim_fs_busy", busy, 0);

    // tick and btn_rise together at count=3 -> 3
    do_arm();
    cyc(1);
    do_lights();
    do_ticks(3);
    tick = 1'b1; btn = 1'b1; cyc(1); tick = 1'b0; btn = 1'b0;
    check("sim_tick_valid", react_valid, 1);
    check("sim_tick_time", react_time, 3);
    check("sim_fs_cleared", false_start, 0);
    cyc(1);

    // Button held across arm and lights_out is not a press
    btn = 1'b1;
    cyc(1);
    do_arm();
    do_lights();
    do_ticks(4);
    check("held_busy", busy, 1);
    btn = 1'b0; cyc(1);
    press();
    check("held_valid", react_valid, 1);
    check("held_time", react_time, 4);
    cyc(1);

    // rst clears a false start
    do_arm();
    cyc(1);
    press();
    check("rstfs_set", false_start, 1);
    rst = 1'b1; cyc(1); rst = 1'b0;
    check("rstfs_clear", false_start, 0);

    // rst in TIMING at count=9
    rv_snap = rv_cnt;
    do_arm();
    do_lights();
    do_ticks(9);
    rst = 1'b1; cyc(1); rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_time", react_time, 0);
    check("mid_rst_tmo", timeout_err, 0);
    check("mid_rst_fs", false_start, 0);
    check("mid_rst_valid", react_valid, 0);
    btn = 1'b1; cyc(2); btn = 1'b0; cyc(1);
    check("mid_rst_no_valid", rv_cnt - rv_snap, 0);

    // Saturation on the 4-bit instance; the 16-bit one keeps timing
    rv4_snap = rv4_cnt;
    do_arm();
    do_lights();
    do_ticks(20);
    check("sat_valid_once", rv4_cnt - rv4_snap, 1);
    check("sat_time", react_time4, 15);
    check("sat_tmo", timeout_err4, 1);
    check("sat_busy4", busy4, 0);
    check("sat_wide_busy", busy, 1);
    press();
    check("sat_wide_time", react_time, 20);
    check("sat_wide_tmo", timeout_err, 0);
    cyc(1);
    check("sat_ignored_idle", rv4_cnt - rv4_snap, 1);
    check("sat_time_kept", react_time4, 15);

`ifdef REACTION_BEST_TIME_EN
    rst = 1'b1; cyc(1); rst = 1'b0;
    check("best_init", best_time, 16'hFFFF);
    check("best4_init", best_time4, 15);
    do_arm(); do_lights(); do_ticks(12); press(); cyc(1);
    check("best_r12", best_time, 12);
    check("best4_r12", best_time4, 12);
    do_arm(); do_lights(); do_ticks(8); press(); cyc(1);
    check("best_r8", best_time, 8);
    check("best4_r8", best_time4, 8);
    do_arm(); cyc(1); press(); cyc(1);
    check("best_fs", best_time, 8);
    do_arm(); do_lights(); do_ticks(20); press(); cyc(1);
    check("best_tmo", best_time, 8);
    check("best4_tmo", best_time4, 8);
    do_arm(); do_lights(); do_ticks(10); press(); cyc(1);
    check("best_r10", best_time, 8);
    check("best4_r10", best_time4, 8);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reaction_timer.md
Name: reaction_timer

Overview:
- Downstream consumer of the random-delay stage's one-cycle time_out pulse ("lights out") in the F1 start-light game.
- After a round is armed, measures the number of tick periods between lights out and the player's button press.
- Flags presses made before lights out (false starts) and over-long reactions (timeouts).
- Reports the result to the display/front-end as a registered value with a one-cycle valid pulse.

Parameters:
- CNT_WIDTH, default 16: width of the reaction counter and of react_time. Saturation value MAX = 2^CNT_WIDTH-1.

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- arm  input  1  one-cycle pulse; starts a round (front end issues the delay trigger in the same cycle)
- lights_out  input  1  one-cycle pulse from the delay stage time_out
- tick  input  1  one-cycle timebase pulse (e.g. 1 ms) from the clock-tick generator
- btn  input  1  player button level, already synchronised to clk
- busy  output  1  high in ARMED or TIMING
- react_valid  output  1  one-cycle pulse; react_time/timeout_err valid this cycle
- react_time  output  CNT_WIDTH  last measured reaction in ticks; held until the next result
- timeout_err  output  1  high with react_valid when the counter saturated; held with react_time
- false_start  output  1  level; high from false-start detection until the next accepted arm or rst

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE; count=0; btn_q=0.
  - react_valid=0, react_time=0, timeout_err=0, false_start=0, busy=0.
  - rst overrides every other input in any state, including mid-round.
- Edge detect: btn_rise = btn & ~btn_q; btn_q registered every cycle. Only rising edges count; a button held high is never a press.
- States: IDLE, ARMED, TIMING, DONE, FALSE_START.
- IDLE:
  - arm=1 -> ARMED.
  - lights_out and btn are ignored.
- ARMED:
  - btn_rise=1 -> FALSE_START; set false_start=1. This has priority over lights_out in the same cycle.
  - else lights_out=1 -> TIMING; count<=0.
  - arm is ignored.
- TIMING:
  - btn_rise=1 -> DONE; react_time<=count; timeout_err<=0. A tick in the same cycle is not counted.
  - else count==MAX -> DONE; react_time<=MAX; timeout_err<=1.
  - else tick=1 -> count<=count+1.
  - arm and lights_out are ignored.
- DONE:
  - react_valid=1 for exactly this cycle, then -> IDLE unconditionally.
  - Latency: react_valid is high in the cycle after the btn_rise cycle.
- FALSE_START:
  - react_valid is not asserted; react_time is unchanged.
  - arm=1 -> ARMED; false_start<=0.
- false_start also clears on rst.
- react_time and timeout_err change only on entry to DONE (or reset).
- busy is decoded combinationally from state.
- count never wraps; it saturates at MAX.

Optional Feature:
- Macro: REACTION_BEST_TIME_EN.
- Defined:
  - Extra output port best_time, width CNT_WIDTH; reset value MAX.
  - On each DONE entry with timeout_err=0 and count < best_time: best_time<=count, in the same edge as react_time.
  - False starts, timeouts and arm never modify best_time; only rst restores MAX.
- Undefined: best_time port and register are absent; all other behaviour is identical.

Test Plan:
- Normal round (CNT_WIDTH=16):
  - Stimulus: arm; lights_out 5 cycles later; 7 tick pulses; btn rises 2 cycles after the 7th tick.
  - Required: react_valid pulse one cycle after the btn edge; react_time=7; timeout_err=0; busy high from the cycle after arm until DONE.
- False start:
  - Stimulus: arm; btn rises before lights_out; lights_out arrives later.
  - Required: false_start=1 and stays high; no react_valid; react_time keeps its previous value; lights_out ignored.
  - Follow-up: next arm clears false_start and enters ARMED.
- Simultaneous events:
  - btn_rise and lights_out in the same ARMED cycle -> false start.
  - In TIMING with count=3, tick and btn_rise in the same cycle -> react_time=3.
- Saturation (CNT_WIDTH=4):
  - Stimulus: arm, lights_out, 20 ticks, no press.
  - Required: react_valid once, react_time=15, timeout_err=1; later presses are ignored in IDLE.
- Held button and reset mid-round:
  - btn held high across arm and lights_out, then 4 ticks, then btn falls and rises -> react_time=4.
  - A separate round with rst asserted in TIMING at count=9 -> all outputs return to reset values the next cycle; no react_valid.
- REACTION_BEST_TIME_EN:
  - Stimulus: rounds with results 12, 8, false start, timeout, 10.
  - Required: best_time = 65535, 12, 8, 8, 8, 8.
